imem_arbiter: RTL

Two-requester arbiter that shares the single-port, synchronous-read instruction memory between the fetch stage and a load/store (or program-loader) port. It grants at most one access per cycle and returns read data one cycle after the grant, tagged to the winning requester. A starvation guard stops a continuous load/store stream from stalling fetch indefinitely. It sits between the fetch stage / memory stage and the memory macro.

---
 rtl/imem_arb_pkg.sv | 19 +
 rtl/arb_starve_ctr.sv | 35 +++
 rtl/imem_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// The owner encoding tags each one-cycle-delayed read response.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam int MAX_WAIT_DEFAULT = 4;
    localparam int STARVE_W_DEFAULT = $clog2(MAX_WAIT_DEFAULT + 1);

    // Counter width needed to hold 0..max_wait inclusive.
    function automatic int starve_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter: clear has priority, increments stop at MAX.
// o_sat flags that the guarded requester has waited its full allowance.
module arb_starve_ctr
    import imem_arb_pkg::*;
#(
    parameter int MAX = MAX_WAIT_DEFAULT,
    parameter int W   = starve_width(MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_cnt;

    assign o_sat = (r_cnt == MAX_V);

    // Wait count register with clear, saturating increment and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_sat) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous-read instruction memory between fetch and
// load/store; ls wins collisions until fetch has been denied MAX_WAIT cycles.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = MAX_WAIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [31:0]           i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    input  logic                  i_ls_req,
    input  logic                  i_ls_we,
    input  logic [31:0]           i_ls_addr,
    input  logic [DATA_WIDTH-1:0] i_ls_wdata,
    output logic                  o_ls_gnt,
    output logic                  o_ls_rvalid,
    output logic [DATA_WIDTH-1:0] o_ls_rdata,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int CW = starve_width(MAX_WAIT);

    owner_e r_owner;
    owner_e w_owner_nxt;
    logic   w_if_gnt;
    logic   w_ls_gnt;
    logic   w_sat;

    // Byte-offset and high address bits alias by design.
    logic w_unused_addr;
    assign w_unused_addr = ^{i_if_addr[31:ADDR_WIDTH+2], i_if_addr[1:0],
                             i_ls_addr[31:ADDR_WIDTH+2], i_ls_addr[1:0]};

    arb_starve_ctr #(
        .MAX (MAX_WAIT),
        .W   (CW)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_if_gnt || !i_if_req),
        .i_inc (i_if_req && !w_if_gnt),
        .o_sat (w_sat)
    );

    // Grant selection: single requester wins, ls wins ties unless fetch is starved.
    always_comb begin
        w_if_gnt = 1'b0;
        w_ls_gnt = 1'b0;
        if (rst) begin
            w_if_gnt = 1'b0;
            w_ls_gnt = 1'b0;
        end else if (i_if_req && i_ls_req) begin
            w_if_gnt = w_sat;
            w_ls_gnt = !w_sat;
        end else begin
            w_if_gnt = i_if_req;
            w_ls_gnt = i_ls_req;
        end
    end

    // Memory port steering towards the winning requester.
    always_comb begin
        o_mem_addr = i_if_addr[ADDR_WIDTH+1:2];
        if (w_ls_gnt) begin
            o_mem_addr = i_ls_addr[ADDR_WIDTH+1:2];
        end else begin
            o_mem_addr = i_if_addr[ADDR_WIDTH+1:2];
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_ls_gnt    = w_ls_gnt;
    assign o_mem_en    = w_if_gnt || w_ls_gnt;
    assign o_mem_we    = w_ls_gnt && i_ls_we;
    assign o_mem_wdata = i_ls_wdata;

    // Response owner for the read issued this cycle; writes owe nothing.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_if_gnt) begin
            w_owner_nxt = OWN_IF;
        end else if (w_ls_gnt && !i_ls_we) begin
            w_owner_nxt = OWN_LS;
        end else begin
            w_owner_nxt = OWN_NONE;
        end
    end

    // Owner state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    // rst masks a response owed from the cycle just before reset.
    assign o_if_rvalid = (r_owner == OWN_IF) && !rst;
    assign o_ls_rvalid = (r_owner == OWN_LS) && !rst;
    assign o_if_rdata  = i_mem_rdata;
    assign o_ls_rdata  = i_mem_rdata;

endmodule
